// File: rtl/uart_rx_if.sv
// Serial-in / byte-out bundle for the 8N1 UART receiver.
// The receiver side takes the master modport; the consumer takes the slave modport.
interface uart_rx_if;
    logic       UART_rx;
    logic [7:0] data_out;
    logic       flag_out;
    logic       frame_err;

    modport master (
        input  UART_rx,
        output data_out,
        output flag_out,
        output frame_err
    );

    modport slave (
        output UART_rx,
        input  data_out,
        input  flag_out,
        input  frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, centre sampling, one-cycle
// flag_out on a good frame and frame_err on a low stop bit.
module uart_rx #(
    parameter logic [25:0] CLK  = 26'd50000000,
    parameter logic [16:0] BAUD = 17'd115200
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.master bus
);
    localparam logic [25:0] BAUD_DIV = CLK / 26'(BAUD);
    localparam logic [15:0] BAUD_CLK = BAUD_DIV[15:0];
    localparam logic [15:0] HALF_CLK = BAUD_CLK >> 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  data_r, data_n;
    logic        flag_r, flag_n;
    logic        err_r, err_n;
    logic        sync1, sync2, rx_d;

    // Two-flop synchronizer plus one delay flop for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            sync1 <= bus.UART_rx;
            sync2 <= sync1;
            rx_d  <= sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            data_r <= '0;
            flag_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shift  <= shift_n;
            data_r <= data_n;
            flag_r <= flag_n;
            err_r  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        data_n  = data_r;
        flag_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (rx_d && !sync2)
                    state_n = START;
            end
            START: begin
                if (cnt == HALF_CLK - 16'd1) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    // A high line at start-bit centre was only a glitch.
                    state_n = sync2 ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            DATA: begin
                if (cnt == BAUD_CLK - 16'd1) begin
                    cnt_n          = '0;
                    shift_n[idx]   = sync2;
                    idx_n          = idx + 3'd1;
                    if (idx == 3'd7)
                        state_n = STOP;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            STOP: begin
                if (cnt == BAUD_CLK - 16'd1) begin
                    // Returning at stop-bit centre leaves room for a zero-gap next start.
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (sync2) begin
                        data_n = shift;
                        flag_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.data_out  = data_r;
    assign bus.flag_out  = flag_r;
    assign bus.frame_err = err_r;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: records the line each cycle and decodes it by centre
// sampling relative to each detected falling edge, checking outputs every cycle.
module tb_uart_rx;
    localparam int B     = 434;
    localparam int H     = 217;
    localparam int HSIZE = 131072;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if bus();

    uart_rx #(.CLK(26'd50000000), .BAUD(17'd115200)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit         hist [HSIZE];
    int         cyc;
    bit         busy;
    int         c0;
    bit         m_flag, m_err;
    logic [7:0] m_data;

    int         n_flag = 0;
    int         n_err  = 0;
    logic [7:0] rx_q[$];

    // Line value after posedge i is hist[i]; the receiver sees it through a
    // three-cycle pipeline, so bit k of a frame starting at c0 is read from hist[c0+H+k*B].
    initial begin : model
        logic [7:0] b;
        for (int i = 0; i < HSIZE; i++) hist[i] = 1'b1;
        cyc = 8; busy = 1'b0; c0 = 0;
        m_flag = 1'b0; m_err = 1'b0; m_data = 8'h00;
        forever begin
            @(posedge clk);
            cyc++;
            m_flag = 1'b0;
            m_err  = 1'b0;
            hist[cyc-1] = bus.UART_rx;
            if (rst) begin
                hist[cyc-1] = 1'b1;
                hist[cyc-2] = 1'b1;
                hist[cyc-3] = 1'b1;
                busy   = 1'b0;
                m_data = 8'h00;
            end else if (!busy) begin
                if (hist[cyc-4] == 1'b1 && hist[cyc-3] == 1'b0) begin
                    busy = 1'b1;
                    c0   = cyc - 3;
                end
            end else begin
                if (cyc == c0 + 3 + H && hist[c0+H] == 1'b1) begin
                    busy = 1'b0;
                end else if (cyc == c0 + 3 + H + 9*B) begin
                    for (int k = 0; k < 8; k++) b[k] = hist[c0 + H + (k+1)*B];
                    if (hist[c0 + H + 9*B]) begin
                        m_data = b;
                        m_flag = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    busy = 1'b0;
                end
            end
        end
    end

    initial begin : compare
        logic [7:0] e_data;
        logic       e_flag, e_err;
        forever begin
            @(negedge clk);
            e_data = rst ? 8'h00 : m_data;
            e_flag = rst ? 1'b0  : m_flag;
            e_err  = rst ? 1'b0  : m_err;
            total++;
            if (bus.data_out !== e_data || bus.flag_out !== e_flag || bus.frame_err !== e_err) begin
                bad++;
                $display("FAIL cycle_out t=%0t data/flag/err actual=%h/%b/%b required=%h/%b/%b",
                         $time, bus.data_out, bus.flag_out, bus.frame_err, e_data, e_flag, e_err);
            end
            if (bus.flag_out === 1'b1) begin
                n_flag++;
                rx_q.push_back(bus.data_out);
            end
            if (bus.frame_err === 1'b1) n_err++;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int per, input logic stopb);
        bus.UART_rx = 1'b0;
        hold(per);
        for (int k = 0; k < 8; k++) begin
            bus.UART_rx = b[k];
            hold(per);
        end
        bus.UART_rx = stopb;
        hold(per);
    endtask

    initial begin : stim
        int         f0, e0;
        logic [7:0] rb;
        logic [7:0] part;
        bus.UART_rx = 1'b1;
        rst = 1'b1;
        hold(5);
        chk("reset_data", int'(bus.data_out), 0);
        chk("reset_flag", int'(bus.flag_out), 0);
        chk("reset_err",  int'(bus.frame_err), 0);
        rst = 1'b0;
        hold(20);

        // Single good byte
        f0 = n_flag; e0 = n_err;
        send(8'hA5, B, 1'b1);
        hold(300);
        chk("a5_data",  int'(bus.data_out), 'hA5);
        chk("a5_flags", n_flag - f0, 1);
        chk("a5_err",   n_err - e0, 0);

        // Back-to-back, zero idle
        rx_q.delete(); e0 = n_err;
        send(8'h00, B, 1'b1);
        send(8'hFF, B, 1'b1);
        send(8'h55, B, 1'b1);
        hold(300);
        chk("b2b_count", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            chk("b2b_0", int'(rx_q[0]), 'h00);
            chk("b2b_1", int'(rx_q[1]), 'hFF);
            chk("b2b_2", int'(rx_q[2]), 'h55);
        end
        chk("b2b_err", n_err - e0, 0);

        // Short low glitch, then a real byte
        f0 = n_flag; e0 = n_err;
        bus.UART_rx = 1'b0;
        hold(100);
        bus.UART_rx = 1'b1;
        hold(600);
        chk("glitch_flags", n_flag - f0, 0);
        chk("glitch_err",   n_err - e0, 0);
        send(8'h3C, B, 1'b1);
        hold(300);
        chk("after_glitch_data", int'(bus.data_out), 'h3C);
        chk("after_glitch_flags", n_flag - f0, 1);

        // Bad stop bit, then a long break
        f0 = n_flag; e0 = n_err;
        send(8'h81, B, 1'b0);
        bus.UART_rx = 1'b1;
        hold(600);
        chk("badstop_err",   n_err - e0, 1);
        chk("badstop_flags", n_flag - f0, 0);
        chk("badstop_data",  int'(bus.data_out), 'h3C);
        e0 = n_err;
        bus.UART_rx = 1'b0;
        hold(20 * B);
        bus.UART_rx = 1'b1;
        hold(600);
        chk("break_err",   n_err - e0, 1);
        chk("break_flags", n_flag - f0, 0);

        // Reset during bit 4
        f0 = n_flag; e0 = n_err;
        part = 8'h5A;
        bus.UART_rx = 1'b0;
        hold(B);
        for (int k = 0; k < 4; k++) begin
            bus.UART_rx = part[k];
            hold(B);
        end
        bus.UART_rx = part[4];
        hold(200);
        rst = 1'b1;
        bus.UART_rx = 1'b1;
        hold(1);
        chk("midrst_data", int'(bus.data_out), 0);
        chk("midrst_flag", int'(bus.flag_out), 0);
        chk("midrst_err",  int'(bus.frame_err), 0);
        hold(4);
        rst = 1'b0;
        hold(50);
        chk("midrst_nopulse", (n_flag - f0) + (n_err - e0), 0);
        send(8'hC3, B, 1'b1);
        hold(300);
        chk("c3_data",  int'(bus.data_out), 'hC3);
        chk("c3_flags", n_flag - f0, 1);

        // Bit-period tolerance
        rx_q.delete();
        send(8'h96, B - 8, 1'b1);
        bus.UART_rx = 1'b1;
        hold(300);
        send(8'h96, B + 8, 1'b1);
        hold(300);
        chk("tol_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("tol_fast", int'(rx_q[0]), 'h96);
            chk("tol_slow", int'(rx_q[1]), 'h96);
        end

        // Randomized frames against the model
        for (int n = 0; n < 4; n++) begin
            rb = 8'($urandom);
            send(rb, int'($urandom_range(438, 430)), ($urandom_range(7, 0) != 0));
            bus.UART_rx = 1'b1;
            hold(int'($urandom_range(40, 0)));
        end
        hold(4500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK, default 26'd50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 17'd115200, serial bit rate in baud.
REQ-003 Port clk  input  1  single system clock, all logic on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port UART_rx  input  1  serial line, asynchronous to clk, idle high, 8N1, LSB first.
REQ-006 Port data_out  output  8  last correctly framed byte received.
REQ-007 Port flag_out  output  1  one-cycle pulse: data_out updated with new valid byte.
REQ-008 Port frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded.

Function
REQ-009 Local constants: Baud_Clk = CLK/BAUD (integer division); Half_Clk = Baud_Clk/2; with defaults these are 434 and 217.
REQ-010 Baud counter SHALL be 16 bits wide, enough for Baud_Clk up to 65535.
REQ-011 UART_rx SHALL pass through a 2-flop synchronizer, then one more delay flop; start edge = delayed 1 and synchronized 0.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; encoding is free.
REQ-013 IDLE: baud counter held at 0; on start edge go to START.
REQ-014 START: count to Half_Clk-1, then sample the synchronized line; if 0, go to DATA with counter 0 and bit index 0; if 1 (glitch), go to IDLE with no output pulse.
REQ-015 DATA: when counter reaches Baud_Clk-1, sample the line into shift register bit [bit index], increment index, and clear the counter; after index 7 is sampled, go to STOP.
REQ-016 STOP: when counter reaches Baud_Clk-1, sample the line.
REQ-017 STOP sample = 1: load data_out from the shift register, pulse flag_out high for exactly one cycle, and go to IDLE.
REQ-018 STOP sample = 0: pulse frame_err for one cycle, leave data_out unchanged, and go to IDLE.
REQ-019 All samples SHALL be taken at bit centre, Half_Clk + k*Baud_Clk cycles after the detected start edge.
REQ-020 flag_out and frame_err SHALL never assert in the same cycle.
REQ-021 Each flag_out or frame_err pulse SHALL follow the start edge detection by Half_Clk + 9*Baud_Clk cycles.
REQ-022 data_out SHALL hold its value until the next good frame; no read handshake or overrun detection.
REQ-023 A line held low (break) SHALL produce one frame_err, then no further activity until the line goes high and falls again.
REQ-024 Falling edges during START, DATA or STOP SHALL be ignored; no re-synchronization mid-frame.
REQ-025 Back-to-back frames with zero idle between the stop bit and the next start bit SHALL be received without loss, because the FSM returns to IDLE at stop-bit centre.

Reset
REQ-026 While rst = 1: FSM in IDLE; counter, bit index and shift register = 0; data_out = 8'h00; flag_out = 0; frame_err = 0; synchronizer and delay flops = 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no pulse.
REQ-028 After reset release, reception SHALL restart only on a fresh high-to-low edge.

Verification
REQ-029 Defaults; drive 8'hA5 as 8N1 at 434 clk/bit -> single flag_out pulse, data_out = 8'hA5, frame_err stays 0.
REQ-030 Bytes 8'h00, 8'hFF, 8'h55 back-to-back, no idle gap -> three flag_out pulses, data_out = 00, FF, 55 in order.
REQ-031 100-cycle low glitch on the idle line -> no flag_out, no frame_err, FSM back in IDLE; a following 8'h3C is received correctly.
REQ-032 8'h81 sent with stop bit forced 0 -> one frame_err pulse, data_out keeps its previous value; line held low 20 bit times -> exactly one frame_err.
REQ-033 rst pulsed during bit 4 of a frame -> outputs 0, no pulse; next frame 8'hC3 received correctly.
REQ-034 Transmit bit period of 434±8 cycles with byte 8'h96 -> data_out = 8'h96, confirming centre-sampling tolerance.
